// File: rtl/mc_main_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute over a shared datapath,
// with memory wait-state timeout, illegal-opcode trap, SYSTEM pulse and retire counter.
module mc_main_controller #(
  parameter int MEM_TIMEOUT  = 255,
  parameter int TMO_W        = 8,
  parameter int ILLEGAL_TRAP = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       imm_src,
  output logic [1:0]       alu_op,
  output logic             system_evt,
  output logic             illegal,
  output logic             bus_error,
  output logic [CNT_W-1:0] instret
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JALRADR, S_JAL, S_UPPER, S_TRAP, S_BERR
  } state_t;

  localparam logic [TMO_W-1:0] TMO = TMO_W'(MEM_TIMEOUT);

  state_t           state, state_n;
  logic [TMO_W-1:0] wcnt;
  logic             in_mem, tmo_hit;

  assign in_mem  = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign tmo_hit = (MEM_TIMEOUT != 0) && (wcnt == TMO) && !mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      wcnt    <= '0;
      instret <= '0;
    end else begin
      state <= state_n;
      // Any state change clears the counter, which covers entry to the three memory states.
      if (state_n != state)
        wcnt <= '0;
      else if (in_mem && !mem_ready)
        wcnt <= wcnt + TMO_W'(1);
      if (state_n == S_FETCH && state != S_FETCH)
        instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    state_n    = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = 3'b000;
    alu_op     = 2'b00;
    system_evt = 1'b0;
    illegal    = 1'b0;
    bus_error  = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          pc_write   = 1'b1;
          state_n    = S_DECODE;
        end else if (tmo_hit) begin
          state_n = S_BERR;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b010;
        case (opcode)
          7'b0110011:             state_n = S_EXECR;
          7'b0010011:             state_n = S_EXECI;
          7'b0000011, 7'b0100011: state_n = S_MEMADR;
          7'b1100011:             state_n = S_BRANCH;
          7'b1101111:             state_n = S_JAL;
          7'b1100111:             state_n = S_JALRADR;
          7'b0110111, 7'b0010111: state_n = S_UPPER;
          7'b0001111:             state_n = S_FETCH;
          7'b1110011: begin
            system_evt = 1'b1;
            state_n    = S_FETCH;
          end
          default:                state_n = (ILLEGAL_TRAP != 0) ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = opcode[5] ? 3'b001 : 3'b000;
        state_n   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)    state_n = S_MEMWB;
        else if (tmo_hit) state_n = S_BERR;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_n    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)    state_n = S_FETCH;
        else if (tmo_hit) state_n = S_BERR;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_n   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_n   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_n   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = branch_taken;
        state_n   = S_FETCH;
      end
      S_JALRADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_n   = S_JAL;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        imm_src   = 3'b011;
        pc_write  = 1'b1;
        state_n   = S_ALUWB;
      end
      S_UPPER: begin
        alu_src_a = opcode[5] ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b100;
        state_n   = S_ALUWB;
      end
      S_TRAP:  illegal   = 1'b1;
      S_BERR:  bus_error = 1'b1;
      default: state_n   = S_FETCH;
    endcase
    // Reset silences every control, including the FETCH memory request.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      imm_src    = 3'b000;
      alu_op     = 2'b00;
      system_evt = 1'b0;
      illegal    = 1'b0;
      bus_error  = 1'b0;
    end
  end
endmodule

// File: tb/tb_mc_main_controller.sv
// Scoreboard bench for mc_main_controller: per-cycle expected control vectors are queued
// with their stimulus and compared by a monitor on the falling edge.
module tb_mc_main_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n[2];
  logic [6:0] opc[2];
  logic       rdy[2];
  logic       bt[2];
  logic       mem_req[2], mem_we[2], adr_src[2], ir_write[2], pc_write[2], reg_write[2];
  logic [1:0] result_src[2], alu_src_a[2], alu_src_b[2], alu_op[2];
  logic [2:0] imm_src[2];
  logic       system_evt[2], illegal[2], bus_error[2];
  logic [31:0] instret_a;
  logic [3:0]  instret_b;
  logic [19:0] ctl[2];

  mc_main_controller #(.MEM_TIMEOUT(4), .TMO_W(8), .ILLEGAL_TRAP(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n[0]), .opcode(opc[0]), .branch_taken(bt[0]), .mem_ready(rdy[0]),
    .mem_req(mem_req[0]), .mem_we(mem_we[0]), .adr_src(adr_src[0]), .ir_write(ir_write[0]),
    .pc_write(pc_write[0]), .reg_write(reg_write[0]), .result_src(result_src[0]),
    .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]), .imm_src(imm_src[0]), .alu_op(alu_op[0]),
    .system_evt(system_evt[0]), .illegal(illegal[0]), .bus_error(bus_error[0]), .instret(instret_a));

  mc_main_controller #(.MEM_TIMEOUT(255), .TMO_W(8), .ILLEGAL_TRAP(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n[1]), .opcode(opc[1]), .branch_taken(bt[1]), .mem_ready(rdy[1]),
    .mem_req(mem_req[1]), .mem_we(mem_we[1]), .adr_src(adr_src[1]), .ir_write(ir_write[1]),
    .pc_write(pc_write[1]), .reg_write(reg_write[1]), .result_src(result_src[1]),
    .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]), .imm_src(imm_src[1]), .alu_op(alu_op[1]),
    .system_evt(system_evt[1]), .illegal(illegal[1]), .bus_error(bus_error[1]), .instret(instret_b));

  for (genvar g = 0; g < 2; g++) begin : g_ctl
    assign ctl[g] = {mem_req[g], mem_we[g], adr_src[g], ir_write[g], pc_write[g], reg_write[g],
                     result_src[g], alu_src_a[g], alu_src_b[g], imm_src[g], alu_op[g],
                     system_evt[g], illegal[g], bus_error[g]};
  end

  function automatic logic [19:0] mk(input logic req, input logic we, input logic adr,
      input logic irw, input logic pcw, input logic rw, input logic [1:0] rs,
      input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] imm,
      input logic [1:0] op, input logic sys, input logic ill, input logic be);
    return {req, we, adr, irw, pcw, rw, rs, sa, sb, imm, op, sys, ill, be};
  endfunction

  localparam logic [19:0] F_RDY = mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0,0);
  localparam logic [19:0] F_STL = mk(1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0);
  localparam logic [19:0] DEC   = mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,3'b010,2'b00,0,0,0);
  localparam logic [19:0] DECS  = mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,3'b010,2'b00,1,0,0);
  localparam logic [19:0] EXR   = mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,2'b10,0,0,0);
  localparam logic [19:0] EXI   = mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b10,0,0,0);
  localparam logic [19:0] AWB   = mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0);
  localparam logic [19:0] MADL  = mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0,0);
  localparam logic [19:0] MADS  = mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b001,2'b00,0,0,0);
  localparam logic [19:0] MRD   = mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0);
  localparam logic [19:0] MWB   = mk(0,0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,2'b00,0,0,0);
  localparam logic [19:0] MWR   = mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0);
  localparam logic [19:0] BR_T  = mk(0,0,0,0,1,0,2'b00,2'b10,2'b00,3'b000,2'b01,0,0,0);
  localparam logic [19:0] BR_N  = mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,2'b01,0,0,0);
  localparam logic [19:0] JRA   = mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0,0);
  localparam logic [19:0] JALS  = mk(0,0,0,0,1,0,2'b00,2'b01,2'b10,3'b011,2'b00,0,0,0);
  localparam logic [19:0] LUIS  = mk(0,0,0,0,0,0,2'b00,2'b11,2'b01,3'b100,2'b00,0,0,0);
  localparam logic [19:0] AUIS  = mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,3'b100,2'b00,0,0,0);
  localparam logic [19:0] TRAPS = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,1,0);
  localparam logic [19:0] BERRS = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,1);

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
    OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_LUI = 7'b0110111, OP_AUI = 7'b0010111, OP_FEN = 7'b0001111, OP_SYS = 7'b1110011,
    OP_BAD = 7'b1111111;

  typedef struct { logic [6:0] opc; logic rdy; logic bt; logic [19:0] exp; string tag; } step_t;
  typedef struct { int sel; logic [19:0] exp; string tag; } ex_t;
  step_t stimq[$];
  ex_t   expq[$];
  ex_t   cur;
  int    checks = 0, failures = 0;
  int    ei_a = 0, ei_b = 0;

  task automatic st(input logic [6:0] o, input logic r, input logic b, input logic [19:0] e,
                    input string t);
    stimq.push_back('{o, r, b, e, t});
  endtask

  // Drives queued steps one per cycle; each step's expected vector goes to the scoreboard.
  task automatic play(input int sel);
    step_t s;
    while (stimq.size() > 0) begin
      s = stimq.pop_front();
      @(negedge clk);
      opc[sel] = s.opc; rdy[sel] = s.rdy; bt[sel] = s.bt;
      expq.push_back('{sel, s.exp, s.tag});
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    #1;
    if (expq.size() > 0) begin
      cur = expq.pop_front();
      checks++;
      if (ctl[cur.sel] !== cur.exp) begin
        failures++;
        $display("FAIL %s dut%0d: ctl got %h want %h", cur.tag, cur.sel, ctl[cur.sel], cur.exp);
      end
    end
  end

  task automatic test_reset;
    @(negedge clk);
    rst_n[0] = 1'b0; rdy[0] = 1'b1;
    #1;
    checks++;
    if (ctl[0] !== 20'h0) begin
      failures++; $display("FAIL reset_ctl: got %h want 00000", ctl[0]);
    end
    checks++;
    if (instret_a !== 32'd0) begin
      failures++; $display("FAIL reset_instret: got %0d want 0", instret_a);
    end
    ei_a = 0;
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
  endtask

  task automatic test_instret_a(input string t);
    checks++;
    if (instret_a !== 32'(ei_a)) begin
      failures++; $display("FAIL %s: instret got %0d want %0d", t, instret_a, ei_a);
    end
  endtask

  task automatic test_add;
    st(OP_R,1,0,F_RDY,"add_fetch"); st(OP_R,1,0,DEC,"add_dec");
    st(OP_R,1,0,EXR,"add_exec"); st(OP_R,1,0,AWB,"add_wb");
    play(0); ei_a++; test_instret_a("add_instret");
  endtask

  task automatic test_lw_stall;
    st(OP_LD,1,0,F_RDY,"lw_fetch"); st(OP_LD,1,0,DEC,"lw_dec"); st(OP_LD,1,0,MADL,"lw_adr");
    for (int i = 0; i < 3; i++) st(OP_LD,0,0,MRD,"lw_rd_stall");
    st(OP_LD,1,0,MRD,"lw_rd"); st(OP_LD,1,0,MWB,"lw_wb");
    play(0); ei_a++; test_instret_a("lw_instret");
  endtask

  task automatic test_sw_addi;
    st(OP_ST,1,0,F_RDY,"sw_fetch"); st(OP_ST,1,0,DEC,"sw_dec");
    st(OP_ST,1,0,MADS,"sw_adr"); st(OP_ST,1,0,MWR,"sw_wr");
    st(OP_I,1,0,F_RDY,"addi_fetch"); st(OP_I,1,0,DEC,"addi_dec");
    st(OP_I,1,0,EXI,"addi_exec"); st(OP_I,1,0,AWB,"addi_wb");
    play(0); ei_a += 2; test_instret_a("sw_addi_instret");
  endtask

  task automatic test_branch;
    st(OP_BR,1,1,F_RDY,"beq_t_fetch"); st(OP_BR,1,1,DEC,"beq_t_dec"); st(OP_BR,1,1,BR_T,"beq_taken");
    st(OP_BR,1,0,F_RDY,"beq_n_fetch"); st(OP_BR,1,0,DEC,"beq_n_dec"); st(OP_BR,1,0,BR_N,"beq_not");
    play(0); ei_a += 2; test_instret_a("branch_instret");
  endtask

  task automatic test_jumps;
    st(OP_JAL,1,0,F_RDY,"jal_fetch"); st(OP_JAL,1,0,DEC,"jal_dec");
    st(OP_JAL,1,0,JALS,"jal_jal"); st(OP_JAL,1,0,AWB,"jal_wb");
    st(OP_JALR,1,0,F_RDY,"jalr_fetch"); st(OP_JALR,1,0,DEC,"jalr_dec");
    st(OP_JALR,1,0,JRA,"jalr_adr"); st(OP_JALR,1,0,JALS,"jalr_jal"); st(OP_JALR,1,0,AWB,"jalr_wb");
    play(0); ei_a += 2; test_instret_a("jump_instret");
  endtask

  task automatic test_upper;
    st(OP_LUI,1,0,F_RDY,"lui_fetch"); st(OP_LUI,1,0,DEC,"lui_dec");
    st(OP_LUI,1,0,LUIS,"lui_up"); st(OP_LUI,1,0,AWB,"lui_wb");
    st(OP_AUI,1,0,F_RDY,"aui_fetch"); st(OP_AUI,1,0,DEC,"aui_dec");
    st(OP_AUI,1,0,AUIS,"aui_up"); st(OP_AUI,1,0,AWB,"aui_wb");
    play(0); ei_a += 2; test_instret_a("upper_instret");
  endtask

  task automatic test_fence_system;
    st(OP_FEN,0,0,F_STL,"fen_stall"); st(OP_FEN,0,0,F_STL,"fen_stall");
    st(OP_FEN,1,0,F_RDY,"fen_fetch"); st(OP_FEN,1,0,DEC,"fen_dec");
    st(OP_SYS,1,0,F_RDY,"sys_fetch"); st(OP_SYS,1,0,DECS,"sys_dec");
    play(0); ei_a += 2; test_instret_a("fence_sys_instret");
  endtask

  task automatic test_back_to_back;
    // Four stalls land the wait counter on the timeout value; ready that cycle must win.
    for (int i = 0; i < 4; i++) st(OP_R,0,0,F_STL,"b2b_stall");
    st(OP_R,1,0,F_RDY,"b2b_fetch"); st(OP_R,1,0,DEC,"b2b_dec");
    st(OP_R,1,0,EXR,"b2b_exec"); st(OP_R,1,0,AWB,"b2b_wb");
    play(0); ei_a++; test_instret_a("b2b_instret");
  endtask

  task automatic test_illegal;
    st(OP_BAD,1,0,F_RDY,"ill_fetch"); st(OP_BAD,1,0,DEC,"ill_dec");
    for (int i = 0; i < 20; i++) st(OP_BAD,1,0,TRAPS,"ill_trap");
    play(0); test_instret_a("ill_instret");
  endtask

  task automatic test_timeout;
    test_reset();
    st(OP_R,1,0,F_RDY,"to_fetch"); st(OP_R,1,0,DEC,"to_dec");
    st(OP_R,1,0,EXR,"to_exec"); st(OP_R,1,0,AWB,"to_wb");
    for (int i = 0; i < 5; i++) st(OP_R,0,0,F_STL,"to_stall");
    for (int i = 0; i < 3; i++) st(OP_R,1,0,BERRS,"to_berr");
    play(0); ei_a++; test_instret_a("to_instret");
    test_reset();
  endtask

  task automatic test_reset_mid;
    st(OP_ST,1,0,F_RDY,"mid_fetch"); st(OP_ST,1,0,DEC,"mid_dec");
    st(OP_ST,1,0,MADS,"mid_adr"); st(OP_ST,0,0,MWR,"mid_wr_stall");
    play(0);
    @(negedge clk);
    rst_n[0] = 1'b0;
    #1;
    checks++;
    if (mem_we[0] !== 1'b0 || ctl[0] !== 20'h0) begin
      failures++; $display("FAIL mid_reset: ctl got %h want 00000", ctl[0]);
    end
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    ei_a = 0;
    st(OP_ST,0,0,F_STL,"mid_refetch");
    play(0); test_instret_a("mid_instret");
  endtask

  task automatic test_nop_wrap;
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    st(OP_BAD,1,0,F_RDY,"nop_fetch"); st(OP_BAD,1,0,DEC,"nop_dec");
    st(OP_R,1,0,F_RDY,"nop_next_fetch");
    play(1); ei_b = 1;
    checks++;
    if (instret_b !== 4'(ei_b)) begin
      failures++; $display("FAIL nop_instret: got %0d want %0d", instret_b, ei_b);
    end
    // Finish the ADD, then 14 FENCEs: 16 retirements wrap the 4-bit counter to 0.
    st(OP_R,1,0,DEC,"wrap_dec"); st(OP_R,1,0,EXR,"wrap_exec"); st(OP_R,1,0,AWB,"wrap_wb");
    for (int i = 0; i < 14; i++) begin
      st(OP_FEN,1,0,F_RDY,"wrap_fetch"); st(OP_FEN,1,0,DEC,"wrap_dec");
    end
    play(1); ei_b += 15;
    checks++;
    if (instret_b !== 4'(ei_b % 16) || ei_b != 16) begin
      failures++; $display("FAIL wrap_instret: got %0d want %0d", instret_b, ei_b % 16);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; opc[i] = 7'h0; rdy[i] = 1'b0; bt[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    test_reset();
    test_add();
    test_lw_stall();
    test_sw_addi();
    test_branch();
    test_jumps();
    test_upper();
    test_fence_system();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_nop_wrap();
    repeat (2) @(posedge clk);
    if (expq.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: %0d entries left want 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_main_controller.md
Name: mc_main_controller

Overview:
- Multicycle successor to the single-cycle main decoder: a Moore-style control FSM that sequences each RV32I instruction over several cycles on a shared datapath (PC, OldPC, IR, ALUOut, Data registers).
- Adds a memory request/ready handshake with a wait-state timeout, an illegal-opcode trap, a SYSTEM event pulse and a retired-instruction counter.
- Sits between the instruction/data memory port and the datapath; the ALU decoder consumes alu_op.

Parameters:
MEM_TIMEOUT, 255, consecutive stalled cycles in a memory state before bus error; 0 disables the timeout.
TMO_W, 8, width of the wait counter; MEM_TIMEOUT must be < 2**TMO_W.
ILLEGAL_TRAP, 1, 1 = unknown opcode enters TRAP; 0 = unknown opcode treated as NOP.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0], valid from DECODE onward
branch_taken  in  1  external compare result (funct3 + flags), sampled in BRANCH
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request
mem_we  out  1  write request
adr_src  out  1  0 = PC, 1 = ALUOut
ir_write  out  1  load IR and OldPC
pc_write  out  1  load PC from the result mux
reg_write  out  1  register-file write enable
result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
alu_op  out  2  00 = add, 01 = sub, 10 = funct decode
system_evt  out  1  one-cycle pulse on a SYSTEM opcode
illegal  out  1  sticky; high while in TRAP
bus_error  out  1  sticky; high while in BERR
instret  out  CNT_W  count of retired instructions

Behaviour:
- Async reset: state = FETCH, wait counter = 0, instret = 0. All outputs are 0 while rst_n is low, including mem_req.
- Outputs are decoded from state, plus mem_ready and branch_taken where stated. Any output not listed for a state is 0.
- FETCH: mem_req=1, adr_src=0.
  - When mem_ready=1: ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_write=1, go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, imm_src=010, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0110011 -> EXECR; 0010011 -> EXECI; 0000011 or 0100011 -> MEMADR; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALRADR; 0110111 or 0010111 -> UPPER.
  - 0001111 (FENCE) -> FETCH.
  - 1110011 (SYSTEM) -> FETCH, with system_evt=1 in this cycle.
  - Any other opcode -> TRAP if ILLEGAL_TRAP, else FETCH.
- MEMADR: alu_src_a=10, alu_src_b=01, imm_src=001 if opcode[5] else 000. Next: MEMWRITE if opcode[5], else MEMREAD.
- MEMREAD: mem_req=1, adr_src=1. Go to MEMWB when mem_ready=1.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. Go to FETCH when mem_ready=1.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, imm_src=000, alu_op=10, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=branch_taken, then FETCH.
- JALRADR: alu_src_a=10, alu_src_b=01, imm_src=000, alu_op=00, then JAL.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1, imm_src=011, then ALUWB (rd = OldPC + 4).
- UPPER: alu_src_a = 11 if opcode[5] (LUI), else 01 (AUIPC); alu_src_b=01, imm_src=100, alu_op=00, then ALUWB.
- TRAP and BERR are absorbing states with all controls 0; only reset exits them.
- Wait counter:
  - Cleared on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments on every cycle spent in one of those states with mem_ready=0.
  - If MEM_TIMEOUT != 0 and the counter equals MEM_TIMEOUT while mem_ready=0, go to BERR instead of waiting further.
  - mem_ready=1 in that same cycle takes priority over the timeout.
- instret: increments by 1 on each transition into FETCH from any state other than FETCH, and wraps modulo 2**CNT_W.
  - FENCE and SYSTEM count as retired; TRAP and BERR entries do not.
- Reset asserted mid-instruction: immediate return to FETCH with no partial reg_write, pc_write or mem_we.

Test Plan:
- ADD (opcode 0110011), mem_ready always 1 -> FETCH, DECODE, EXECR, ALUWB, FETCH; reg_write=1 only in ALUWB; instret 0 -> 1.
- LW with mem_ready held low for 3 cycles in MEMREAD -> mem_req=1 and adr_src=1 for 4 cycles, then MEMWB with result_src=01; 5 + 3 = 8 cycles total.
- BEQ: branch_taken=1 gives pc_write=1 in BRANCH; branch_taken=0 gives pc_write=0; both return to FETCH.
- JALR -> JALRADR, JAL, ALUWB; pc_write=1 in JAL with result_src=00; reg_write=1 in ALUWB.
- Opcode 1111111 with ILLEGAL_TRAP=1 -> TRAP, illegal=1, stays there 20 cycles, instret unchanged. Same opcode with ILLEGAL_TRAP=0 -> FETCH and instret +1.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH -> BERR after the 5th stalled cycle with bus_error=1. Then rst_n low -> all outputs 0, instret=0.
